dmem_arbiter: RTL and testbench

Arbitrates single-port access to the 4-bank byte-lane data memory between two requesters. The requesters are the pipeline MEM stage (core port) and the debug/testbench loader port (dbg port). It sits between the MEM-stage lane-steering logic and the four 8-bit BRAM banks. It drives bank enable, write-enables, address and data, and returns registered read data to whichever requester issued the read. Core has priority; a starvation counter and a lock mode guarantee forward progress for the debug port.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_rd_tracker.sv | 42 ++++
 rtl/dmem_arbiter.sv | 128 ++++++++++++
 tb/tb_dmem_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: owner-state encoding and
// bank geometry.
package dmem_pkg;

    typedef enum logic [1:0] {
        S_NORMAL   = 2'd0,
        S_DBG_PRIO = 2'd1,
        S_DBG_LOCK = 2'd2
    } owner_e;

    localparam int DMEM_ADDR_W = 13;
    localparam int NUM_LANES   = 4;

endpackage

// File: rtl/dmem_rd_tracker.sv
// One-cycle read-return tracking: remembers which port issued a read and
// steers the BRAM output to that port in the following cycle.
module dmem_rd_tracker
    import dmem_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_rd_i,
    input  logic        dbg_rd_i,
    input  logic [31:0] mem_dout_i,
    output logic        core_rvalid_o,
    output logic [31:0] core_rdata_o,
    output logic        dbg_rvalid_o,
    output logic [31:0] dbg_rdata_o
);

    logic        core_pend_q;
    logic        dbg_pend_q;
    logic [31:0] core_rdata_q;
    logic [31:0] dbg_rdata_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            core_pend_q  <= 1'b0;
            dbg_pend_q   <= 1'b0;
            core_rdata_q <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            core_pend_q <= core_rd_i;
            dbg_pend_q  <= dbg_rd_i;
            if (core_pend_q) core_rdata_q <= mem_dout_i;
            if (dbg_pend_q)  dbg_rdata_q  <= mem_dout_i;
        end
    end

    // BRAM data is live during the return cycle; the registers only hold it afterwards.
    assign core_rvalid_o = core_pend_q;
    assign dbg_rvalid_o  = dbg_pend_q;
    assign core_rdata_o  = core_pend_q ? mem_dout_i : core_rdata_q;
    assign dbg_rdata_o   = dbg_pend_q  ? mem_dout_i : dbg_rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the 4-bank byte-lane data memory. Core has
// priority; a starvation counter and a lock mode keep the debug port moving.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W       = DMEM_ADDR_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [31:0]       core_addr_i,
    input  logic [3:0]        core_be_i,
    input  logic [31:0]       core_wdata_i,
    output logic              core_gnt_o,
    output logic              core_rvalid_o,
    output logic [31:0]       core_rdata_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [31:0]       dbg_addr_i,
    input  logic [3:0]        dbg_be_i,
    input  logic [31:0]       dbg_wdata_i,
    input  logic              dbg_lock_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [31:0]       dbg_rdata_o,
    output logic              mem_ena_o,
    output logic [3:0]        mem_wea_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_din_o,
    input  logic [31:0]       mem_dout_i,
    output logic [1:0]        owner_o
);

    // Handshake: a port's access is taken in the cycle where req and gnt are both
    // high; gnt already includes req, so gnt alone marks acceptance.
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    owner_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_NORMAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        core_gnt_o = 1'b0;
        dbg_gnt_o  = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_NORMAL: begin
                core_gnt_o = core_req_i;
                dbg_gnt_o  = dbg_req_i && !core_req_i;
                if (dbg_gnt_o) begin
                    cnt_d = '0;
                    if (dbg_lock_i) state_d = S_DBG_LOCK;
                end else if (dbg_req_i) begin
                    cnt_d = (cnt_q >= LIMIT) ? LIMIT : cnt_q + 4'd1;
                    if (cnt_d == LIMIT) state_d = S_DBG_PRIO;
                end else begin
                    cnt_d = '0;
                end
            end
            S_DBG_PRIO: begin
                dbg_gnt_o  = dbg_req_i;
                core_gnt_o = core_req_i && !dbg_req_i;
                cnt_d      = '0;
                if (dbg_gnt_o && dbg_lock_i) state_d = S_DBG_LOCK;
                else                         state_d = S_NORMAL;
            end
            S_DBG_LOCK: begin
                dbg_gnt_o = dbg_req_i;
                cnt_d     = '0;
                // Dropping lock releases ownership whether or not dbg is still requesting.
                if (!dbg_lock_i) state_d = S_NORMAL;
            end
            default: begin
                state_d = S_NORMAL;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        mem_ena_o  = 1'b0;
        mem_wea_o  = '0;
        mem_addr_o = '0;
        mem_din_o  = '0;
        if (core_gnt_o) begin
            mem_ena_o  = 1'b1;
            mem_wea_o  = core_we_i ? core_be_i : 4'b0000;
            mem_addr_o = core_addr_i[ADDR_W+1:2];
            mem_din_o  = core_wdata_i;
        end else if (dbg_gnt_o) begin
            mem_ena_o  = 1'b1;
            mem_wea_o  = dbg_we_i ? dbg_be_i : 4'b0000;
            mem_addr_o = dbg_addr_i[ADDR_W+1:2];
            mem_din_o  = dbg_wdata_i;
        end
    end

    dmem_rd_tracker u_rd_tracker (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .core_rd_i     (core_gnt_o && !core_we_i),
        .dbg_rd_i      (dbg_gnt_o && !dbg_we_i),
        .mem_dout_i    (mem_dout_i),
        .core_rvalid_o (core_rvalid_o),
        .core_rdata_o  (core_rdata_o),
        .dbg_rvalid_o  (dbg_rvalid_o),
        .dbg_rdata_o   (dbg_rdata_o)
    );

    assign owner_o = state_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{core_addr_i[31:ADDR_W+2], core_addr_i[1:0],
                                dbg_addr_i[31:ADDR_W+2], dbg_addr_i[1:0]};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 4-lane BRAM behind it.
module tb_dmem_arbiter;

    localparam int ADDR_W = 13;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              core_req_i, core_we_i;
    logic [31:0]       core_addr_i, core_wdata_i;
    logic [3:0]        core_be_i;
    logic              core_gnt_o, core_rvalid_o;
    logic [31:0]       core_rdata_o;
    logic              dbg_req_i, dbg_we_i, dbg_lock_i;
    logic [31:0]       dbg_addr_i, dbg_wdata_i;
    logic [3:0]        dbg_be_i;
    logic              dbg_gnt_o, dbg_rvalid_o;
    logic [31:0]       dbg_rdata_o;
    logic              mem_ena_o;
    logic [3:0]        mem_wea_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_din_o;
    logic [31:0]       mem_dout_i;
    logic [1:0]        owner_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_arr [0:(1<<ADDR_W)-1];

    always #5 clk_i = ~clk_i;

    dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .core_req_i    (core_req_i),
        .core_we_i     (core_we_i),
        .core_addr_i   (core_addr_i),
        .core_be_i     (core_be_i),
        .core_wdata_i  (core_wdata_i),
        .core_gnt_o    (core_gnt_o),
        .core_rvalid_o (core_rvalid_o),
        .core_rdata_o  (core_rdata_o),
        .dbg_req_i     (dbg_req_i),
        .dbg_we_i      (dbg_we_i),
        .dbg_addr_i    (dbg_addr_i),
        .dbg_be_i      (dbg_be_i),
        .dbg_wdata_i   (dbg_wdata_i),
        .dbg_lock_i    (dbg_lock_i),
        .dbg_gnt_o     (dbg_gnt_o),
        .dbg_rvalid_o  (dbg_rvalid_o),
        .dbg_rdata_o   (dbg_rdata_o),
        .mem_ena_o     (mem_ena_o),
        .mem_wea_o     (mem_wea_o),
        .mem_addr_o    (mem_addr_o),
        .mem_din_o     (mem_din_o),
        .mem_dout_i    (mem_dout_i),
        .owner_o       (owner_o)
    );

    // Read-first BRAM, one cycle of read latency.
    always @(posedge clk_i) begin
        if (mem_ena_o) begin
            for (int i = 0; i < 4; i++)
                if (mem_wea_o[i]) mem_arr[mem_addr_o][8*i +: 8] <= mem_din_o[8*i +: 8];
            mem_dout_i <= mem_arr[mem_addr_o];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic core_drive(input logic req, input logic we, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] wdata);
        core_req_i = req; core_we_i = we; core_addr_i = addr;
        core_be_i = be; core_wdata_i = wdata;
    endtask

    task automatic dbg_drive(input logic req, input logic we, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wdata, input logic lock);
        dbg_req_i = req; dbg_we_i = we; dbg_addr_i = addr;
        dbg_be_i = be; dbg_wdata_i = wdata; dbg_lock_i = lock;
    endtask

    task automatic idle();
        core_drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        dbg_drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem_arr[i] = 32'h0;
        mem_dout_i = 32'h0;
        idle();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        #1;
        chk("rst_owner", owner_o, 0);
        chk("rst_core_rvalid", core_rvalid_o, 0);
        chk("rst_dbg_rvalid", dbg_rvalid_o, 0);
        chk("rst_core_rdata", core_rdata_o, 0);
        chk("rst_mem_ena", mem_ena_o, 0);

        // Full-word write then read back
        step();
        core_drive(1, 1, 32'h0000_0010, 4'hF, 32'hDEADBEEF);
        #1;
        chk("t1_core_gnt", core_gnt_o, 1);
        chk("t1_dbg_gnt", dbg_gnt_o, 0);
        chk("t1_ena", mem_ena_o, 1);
        chk("t1_wea", mem_wea_o, 4'hF);
        chk("t1_addr", mem_addr_o, 32'h4);
        chk("t1_din", mem_din_o, 32'hDEADBEEF);
        step();
        core_drive(1, 0, 32'h0000_0010, 4'hF, 32'h0);
        #1;
        chk("t1_rd_wea", mem_wea_o, 0);
        chk("t1_rd_addr", mem_addr_o, 32'h4);
        step();
        idle();
        #1;
        chk("t1_core_rvalid", core_rvalid_o, 1);
        chk("t1_core_rdata", core_rdata_o, 32'hDEADBEEF);
        chk("t1_dbg_rvalid", dbg_rvalid_o, 0);

        // Single-byte write into lane 2
        core_drive(1, 1, 32'h0000_0010, 4'b0100, 32'h00AB0000);
        #1;
        chk("t2_wea", mem_wea_o, 4'b0100);
        step();
        core_drive(1, 0, 32'h0000_0010, 4'h0, 32'h0);
        #1;
        step();
        idle();
        #1;
        chk("t2_core_rvalid", core_rvalid_o, 1);
        chk("t2_core_rdata", core_rdata_o, 32'hDEABBEEF);
        step();
        chk("t2_rvalid_drop", core_rvalid_o, 0);
        chk("t2_rdata_hold", core_rdata_o, 32'hDEABBEEF);

        // Both requesting continuously: starvation promotes dbg on the 5th cycle
        core_drive(1, 0, 32'h0, 4'h0, 32'h0);
        dbg_drive(1, 0, 32'h0000_0010, 4'h0, 32'h0, 0);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t3_core_gnt_c%0d", k), core_gnt_o, 1);
            chk($sformatf("t3_dbg_gnt_c%0d", k), dbg_gnt_o, 0);
            chk($sformatf("t3_owner_c%0d", k), owner_o, 0);
            step();
        end
        chk("t3_owner_c4", owner_o, 1);
        chk("t3_dbg_gnt_c4", dbg_gnt_o, 1);
        chk("t3_core_gnt_c4", core_gnt_o, 0);
        chk("t3_addr_c4", mem_addr_o, 32'h4);
        chk("t3_core_rvalid_c4", core_rvalid_o, 1);
        chk("t3_core_rdata_c4", core_rdata_o, 32'h0);
        step();
        chk("t3_owner_c5", owner_o, 0);
        chk("t3_core_gnt_c5", core_gnt_o, 1);
        chk("t3_dbg_gnt_c5", dbg_gnt_o, 0);
        chk("t3_dbg_rvalid_c5", dbg_rvalid_o, 1);
        chk("t3_dbg_rdata_c5", dbg_rdata_o, 32'hDEABBEEF);
        chk("t3_core_rvalid_c5", core_rvalid_o, 0);
        idle();
        step();
        step();

        // Locked dbg burst shuts out core
        dbg_drive(1, 1, 32'h100, 4'hF, 32'h11111111, 1);
        #1;
        chk("t4_dbg_gnt0", dbg_gnt_o, 1);
        chk("t4_addr0", mem_addr_o, 32'h40);
        chk("t4_wea0", mem_wea_o, 4'hF);
        step();
        core_drive(1, 0, 32'h0, 4'h0, 32'h0);
        dbg_drive(1, 1, 32'h104, 4'hF, 32'h22222222, 1);
        #1;
        chk("t4_owner1", owner_o, 2);
        chk("t4_core_gnt1", core_gnt_o, 0);
        chk("t4_dbg_gnt1", dbg_gnt_o, 1);
        chk("t4_addr1", mem_addr_o, 32'h41);
        step();
        dbg_drive(1, 1, 32'h108, 4'hF, 32'h33333333, 1);
        #1;
        chk("t4_core_gnt2", core_gnt_o, 0);
        chk("t4_addr2", mem_addr_o, 32'h42);
        step();
        dbg_drive(1, 0, 32'h104, 4'h0, 32'h0, 0);
        #1;
        chk("t4_owner3", owner_o, 2);
        chk("t4_core_gnt3", core_gnt_o, 0);
        chk("t4_dbg_gnt3", dbg_gnt_o, 1);
        chk("t4_wea3", mem_wea_o, 0);
        step();
        dbg_drive(0, 0, 32'h0, 4'h0, 32'h0, 0);
        #1;
        chk("t4_owner4", owner_o, 0);
        chk("t4_core_gnt4", core_gnt_o, 1);
        chk("t4_dbg_rvalid4", dbg_rvalid_o, 1);
        chk("t4_dbg_rdata4", dbg_rdata_o, 32'h22222222);
        step();
        idle();
        step();

        // Reset while a core read is outstanding
        core_drive(1, 0, 32'h0000_0010, 4'h0, 32'h0);
        #1;
        chk("t5_core_gnt", core_gnt_o, 1);
        step();
        idle();
        #1;
        chk("t5_pre_rvalid", core_rvalid_o, 1);
        rst_i = 1'b1;
        #1;
        chk("t5_core_rvalid", core_rvalid_o, 0);
        chk("t5_core_rdata", core_rdata_o, 0);
        chk("t5_dbg_rvalid", dbg_rvalid_o, 0);
        chk("t5_dbg_rdata", dbg_rdata_o, 0);
        chk("t5_owner", owner_o, 0);
        chk("t5_mem_ena", mem_ena_o, 0);
        #1 rst_i = 1'b0;
        step();
        chk("t5_post_rvalid", core_rvalid_o, 0);

        // Idle memory, then confirm the starve counter restarted from zero
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("t6_ena_c%0d", k), mem_ena_o, 0);
            chk($sformatf("t6_wea_c%0d", k), mem_wea_o, 0);
            step();
        end
        core_drive(1, 0, 32'h0, 4'h0, 32'h0);
        dbg_drive(1, 0, 32'h0, 4'h0, 32'h0, 0);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t6_core_gnt_c%0d", k), core_gnt_o, 1);
            step();
        end
        chk("t6_owner_prio", owner_o, 1);
        chk("t6_dbg_gnt_prio", dbg_gnt_o, 1);
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
